node_turn_sequencer: RTL and testbench

//  Sequences the line follower through a planned route, one junction at a time.
//  - Loads a heading list, then counts junctions seen on the 3-channel LSA (all three sensors dark).
//  - At each junction it issues a relative turn command (straight/right/left/U) to the motion/PID stage.
//  - It waits for that stage to acknowledge before counting the next node.
//  - Sits between the path planner (heading list) and the PID/motor steering logic.

---
 rtl/node_turn_sequencer.sv | 174 +++++++++++++++++
 tb/tb_node_turn_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_turn_sequencer.sv
// node_turn_sequencer
//   Walks the line follower through a planned route one junction at a time.
//   A junction is a run of cycles where all three LSA channels read dark.
//   At each junction the block issues a relative turn command to the motion
//   stage and waits for that stage to acknowledge the turn before it looks
//   for the next junction.
//
// Ports
//   clk_50          system clock
//   rst_n           asynchronous active-low reset
//   start           1-cycle pulse: latch the route and begin
//   direction       absolute heading list, entry i at [2*i +: 2]
//   direction_count number of valid entries, 1..MAX_NODES
//   lsa_1/2/3       left/centre/right 12-bit line-sensor samples
//   turn_ack        motion stage has finished the requested turn
//   turn_req        turn command valid, held until turn_ack
//   turn_code       00 straight, 01 right, 11 left, 10 U-turn
//   heading         current absolute heading (00 N, 01 E, 10 S, 11 W)
//   node_count      nodes consumed so far
//   busy            route in progress
//   done            route finished, held until the next start
module node_turn_sequencer #(
  parameter int         MAX_NODES    = 10,
  parameter int         THR          = 1200,
  parameter int         NODE_CYCLES  = 6,
  parameter int         BLANK_CYCLES = 50000,
  parameter logic [1:0] INIT_HEADING = 2'b10
) (
  input  logic                   clk_50,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2*MAX_NODES-1:0] direction,
  input  logic [5:0]             direction_count,
  input  logic [11:0]            lsa_1,
  input  logic [11:0]            lsa_2,
  input  logic [11:0]            lsa_3,
  input  logic                   turn_ack,
  output logic                   turn_req,
  output logic [1:0]             turn_code,
  output logic [1:0]             heading,
  output logic [5:0]             node_count,
  output logic                   busy,
  output logic                   done
);

  // One counter serves both the blanking and the node-qualification phases,
  // so it is sized for the longer of the two.
  localparam int CNT_MAX = (BLANK_CYCLES > NODE_CYCLES) ? BLANK_CYCLES : NODE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [11:0]      THR_V      = 12'(THR);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] NODE_LAST  = CNT_W'(NODE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
  localparam logic [5:0]       MAX_CNT_V  = 6'(MAX_NODES);

  typedef enum logic [2:0] {IDLE, ARM, FOLLOW, TURN, DONE} state_t;

  state_t                 state_reg;
  logic [2:0]             on_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [2*MAX_NODES-1:0] dir_reg;
  logic [5:0]             count_reg;
  logic [1:0]             nxt_reg;

  logic [1:0] dir_arr [MAX_NODES];
  logic [1:0] nxt_next;
  logic       all_on;
  logic [5:0] node_count_next;

  // Unpack the latched route into an indexable list of headings.
  for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_unpack
    assign dir_arr[gi] = dir_reg[2*gi +: 2];
  end

  // Entry for the node about to be consumed; node_count stays below
  // count_reg <= MAX_NODES whenever this is used.
  always_comb begin
    nxt_next = 2'b00;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (node_count == 6'(i)) nxt_next = dir_arr[i];
    end
  end

  assign all_on          = &on_reg;
  assign node_count_next = node_count + 6'd1;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      on_reg     <= 3'b000;
      cnt_reg    <= '0;
      dir_reg    <= '0;
      count_reg  <= 6'd0;
      nxt_reg    <= 2'b00;
      turn_req   <= 1'b0;
      turn_code  <= 2'b00;
      heading    <= INIT_HEADING;
      node_count <= 6'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Registered sensor qualification: FSM sees the line one cycle late.
      on_reg <= {lsa_3 > THR_V, lsa_2 > THR_V, lsa_1 > THR_V};

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            dir_reg    <= direction;
            count_reg  <= direction_count;
            node_count <= 6'd0;
            heading    <= INIT_HEADING;
            cnt_reg    <= '0;
            if (direction_count == 6'd0 || direction_count > MAX_CNT_V) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              busy      <= 1'b1;
              done      <= 1'b0;
              state_reg <= ARM;
            end
          end
        end

        // Blanking: the robot must leave the previous junction bar for
        // BLANK_CYCLES before a new junction can be recognised.
        ARM: begin
          if (all_on) begin
            cnt_reg <= '0;
          end else if (cnt_reg == BLANK_LAST) begin
            cnt_reg   <= '0;
            state_reg <= FOLLOW;
          end else if (cnt_reg != CNT_TOP) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        FOLLOW: begin
          if (!all_on) begin
            cnt_reg <= '0;
          end else if (cnt_reg == NODE_LAST) begin
            cnt_reg   <= '0;
            nxt_reg   <= nxt_next;
            // Relative turn is the heading difference modulo 4.
            turn_code <= nxt_next - heading;
            turn_req  <= 1'b1;
            state_reg <= TURN;
          end else if (cnt_reg != CNT_TOP) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        TURN: begin
          if (turn_ack && turn_req) begin
            turn_req   <= 1'b0;
            heading    <= nxt_reg;
            node_count <= node_count_next;
            if (node_count_next == count_reg) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= ARM;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_node_turn_sequencer.sv
module tb_node_turn_sequencer;

  localparam int MAX_NODES = 10;
  localparam int BLANK     = 20;
  localparam int NODE      = 6;

  logic                   clk_50 = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [2*MAX_NODES-1:0] direction;
  logic [5:0]             direction_count;
  logic [11:0]            lsa_1, lsa_2, lsa_3;
  logic                   turn_ack;
  logic                   turn_req;
  logic [1:0]             turn_code;
  logic [1:0]             heading;
  logic [5:0]             node_count;
  logic                   busy;
  logic                   done;

  always #10 clk_50 = ~clk_50;

  node_turn_sequencer #(
    .MAX_NODES   (MAX_NODES),
    .THR         (1200),
    .NODE_CYCLES (NODE),
    .BLANK_CYCLES(BLANK),
    .INIT_HEADING(2'b10)
  ) dut (
    .clk_50         (clk_50),
    .rst_n          (rst_n),
    .start          (start),
    .direction      (direction),
    .direction_count(direction_count),
    .lsa_1          (lsa_1),
    .lsa_2          (lsa_2),
    .lsa_3          (lsa_3),
    .turn_ack       (turn_ack),
    .turn_req       (turn_req),
    .turn_code      (turn_code),
    .heading        (heading),
    .node_count     (node_count),
    .busy           (busy),
    .done           (done)
  );

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] hdg_before;
    logic [1:0] hdg_after;
    logic [5:0] cnt_after;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic set_lsa(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    lsa_1 = l;
    lsa_2 = c;
    lsa_3 = r;
  endtask

  // Centre sensor on the line only: ordinary line following, not a junction.
  task automatic set_track();
    set_lsa(12'd0, 12'd3000, 12'd0);
  endtask

  // Scoreboard model: walk the route from the start heading, one entry per node.
  task automatic push_route(input logic [1:0] e0, input logic [1:0] e1, input int cnt);
    logic [1:0] h;
    logic [1:0] ent;
    exp_t       e;
    h = 2'b10;
    for (int i = 0; i < cnt; i++) begin
      ent          = (i == 0) ? e0 : e1;
      e.code       = ent - h;
      e.hdg_before = h;
      e.hdg_after  = ent;
      e.cnt_after  = 6'(i + 1);
      sb.push_back(e);
      h = ent;
    end
  endtask

  task automatic do_start(input logic [1:0] e0, input logic [1:0] e1, input logic [5:0] cnt);
    direction       = '0;
    direction[1:0]  = e0;
    direction[3:2]  = e1;
    direction_count = cnt;
    start           = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Blank, present a junction, expect the next scoreboard turn; optionally acknowledge.
  task automatic run_node(input string tag, input bit do_ack);
    bit   seen;
    exp_t e;
    set_track();
    tick(BLANK + 4);
    set_lsa(12'd3000, 12'd3000, 12'd3000);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      seen = turn_req;
    end
    chk({tag, "_turn_req_seen"}, 32'(seen), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      $display("turn %s: code=%b heading=%b node_count=%0d", tag, turn_code, heading, node_count);
      chk({tag, "_turn_code"}, 32'(turn_code), 32'(e.code));
      chk({tag, "_heading_before"}, 32'(heading), 32'(e.hdg_before));
      tick(3);
      chk({tag, "_req_held"}, 32'(turn_req), 32'd1);
      chk({tag, "_code_stable"}, 32'(turn_code), 32'(e.code));
      if (do_ack) begin
        turn_ack = 1'b1;
        tick(1);
        turn_ack = 1'b0;
        chk({tag, "_req_dropped"}, 32'(turn_req), 32'd0);
        chk({tag, "_heading_after"}, 32'(heading), 32'(e.hdg_after));
        chk({tag, "_node_count"}, 32'(node_count), 32'(e.cnt_after));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_turn_req"}, 32'(turn_req), 32'd0);
    chk({tag, "_turn_code"}, 32'(turn_code), 32'd0);
    chk({tag, "_heading"}, 32'(heading), 32'd2);
    chk({tag, "_node_count"}, 32'(node_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int req_hits;
    rst_n           = 1'b0;
    start           = 1'b0;
    direction       = '0;
    direction_count = 6'd0;
    turn_ack        = 1'b0;
    set_track();
    tick(2);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // Route A: S -> E (left) -> S (right).
    push_route(2'b01, 2'b10, 2);
    do_start(2'b01, 2'b10, 6'd2);
    $display("start A: busy=%b done=%b", busy, done);
    chk("A_busy", 32'(busy), 32'd1);
    chk("A_done", 32'(done), 32'd0);
    set_track();
    tick(BLANK + 4);

    // Stray ack and a second start while following: both must be ignored.
    turn_ack = 1'b1;
    direction = '0;
    direction_count = 6'd1;
    start = 1'b1;
    tick(1);
    turn_ack = 1'b0;
    start = 1'b0;
    tick(3);
    chk("ign_turn_req", 32'(turn_req), 32'd0);
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_node_count", 32'(node_count), 32'd0);
    chk("ign_heading", 32'(heading), 32'd2);

    // Junction glitch one cycle short of qualification.
    set_lsa(12'd3000, 12'd3000, 12'd3000);
    tick(NODE - 1);
    set_track();
    tick(10);
    chk("glitch_turn_req", 32'(turn_req), 32'd0);
    chk("glitch_node_count", 32'(node_count), 32'd0);

    // A sample exactly at threshold is not on the line.
    set_lsa(12'd1200, 12'd3000, 12'd3000);
    tick(12);
    chk("thr_turn_req", 32'(turn_req), 32'd0);

    run_node("A1", 1'b1);

    // Still parked on the junction bar: must not recount.
    set_lsa(12'd3000, 12'd3000, 12'd3000);
    req_hits = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (turn_req) req_hits++;
    end
    chk("bar_hold_no_req", 32'(req_hits), 32'd0);
    chk("bar_hold_count", 32'(node_count), 32'd1);

    // Blanking interrupted before completion, then another bar.
    set_track();
    tick(BLANK - 3);
    set_lsa(12'd3000, 12'd3000, 12'd3000);
    tick(12);
    chk("short_blank_no_req", 32'(turn_req), 32'd0);

    run_node("A2", 1'b1);
    $display("end A: done=%b busy=%b node_count=%0d", done, busy, node_count);
    chk("A_done_end", 32'(done), 32'd1);
    chk("A_busy_end", 32'(busy), 32'd0);
    chk("A_sb_empty", 32'(sb.size()), 32'd0);

    turn_ack = 1'b1;
    tick(1);
    turn_ack = 1'b0;
    tick(1);
    chk("done_ack_ignored", 32'(node_count), 32'd2);

    // Route B: S -> N (U-turn) -> S (U-turn); reset while the second turn is pending.
    push_route(2'b00, 2'b10, 2);
    do_start(2'b00, 2'b10, 6'd2);
    chk("B_busy", 32'(busy), 32'd1);
    chk("B_count_cleared", 32'(node_count), 32'd0);
    run_node("B1", 1'b1);
    run_node("B2", 1'b0);
    #3;
    rst_n = 1'b0;
    tick(1);
    $display("reset mid-turn: turn_req=%b busy=%b", turn_req, busy);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    tick(1);
    turn_ack = 1'b1;
    set_lsa(12'd3000, 12'd3000, 12'd3000);
    tick(NODE + 3);
    turn_ack = 1'b0;
    chk("idle_turn_req", 32'(turn_req), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Empty and oversized routes finish immediately.
    do_start(2'b00, 2'b00, 6'd0);
    $display("start count=0: done=%b busy=%b", done, busy);
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd0);
    chk("cnt0_req", 32'(turn_req), 32'd0);
    do_start(2'b00, 2'b00, 6'd11);
    chk("cnt11_done", 32'(done), 32'd1);
    chk("cnt11_busy", 32'(busy), 32'd0);

    // Route C from DONE: S -> W (right), single node.
    push_route(2'b11, 2'b00, 1);
    do_start(2'b11, 2'b00, 6'd1);
    chk("C_busy", 32'(busy), 32'd1);
    chk("C_done_cleared", 32'(done), 32'd0);
    run_node("C1", 1'b1);
    chk("C_done_end", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
